serial_word_feeder: RTL and testbench

SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

---
 rtl/serial_word_feeder.sv | 167 ++++++++++++++++
 tb/tb_serial_word_feeder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// ---------------------------------------------------------------------------
// serial_word_feeder
//
// Accepts parallel words over a valid/ready handshake and emits them one bit
// per clock, LSB first, with framing flags for a downstream bit-serial stage.
// One word is shifting while a second may wait in a one-deep pending buffer.
// Back-to-back words are emitted without a gap.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   load_data   in   [WIDTH] parallel word to serialise
//   load_valid  in   load_data offered this cycle
//   load_ready  out  a word can be accepted this cycle (pending buffer empty)
//   ser_out     out  serial bit (0 whenever ser_valid=0)
//   ser_valid   out  ser_out carries a real bit
//   ser_first   out  ser_out is bit 0 of a word (downstream per-word reset)
//   ser_last    out  ser_out is bit WIDTH-1 of a word
//   words_sent  out  [16] completed-word count, wraps at 2^16
// ---------------------------------------------------------------------------
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic [15:0]      words_sent
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_first_q, ser_first_d;
  logic              ser_last_q, ser_last_d;
  logic [15:0]       words_sent_q, words_sent_d;

  logic              accept;
  logic              start;
  logic [WIDTH-1:0]  start_word;

  // Ready is withheld during reset so no transfer can slip in alongside it.
  assign load_ready = !reset && !pend_full_q;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    ser_first_d  = ser_first_q;
    ser_last_d   = ser_last_q;
    words_sent_d = words_sent_q;
    start        = 1'b0;
    start_word   = load_data;

    case (state_q)
      IDLE: begin
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        if (accept) begin
          start = 1'b1;
        end
      end

      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          // Word completes this cycle; pick the follow-on word, buffered
          // one first, so there is no bubble between words.
          words_sent_d = words_sent_q + 16'd1;
          if (pend_full_q) begin
            start       = 1'b1;
            start_word  = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            start = 1'b1;
          end else begin
            state_d     = IDLE;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_first_d = 1'b0;
            ser_last_d  = 1'b0;
          end
        end else begin
          sh_d        = sh_q >> 1;
          idx_d       = idx_q + IDX_W'(1);
          ser_out_d   = sh_q[1];
          ser_valid_d = 1'b1;
          ser_first_d = 1'b0;
          ser_last_d  = (idx_q == PENULT_IDX);
          if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
          end
        end
      end
    endcase

    if (start) begin
      state_d     = SHIFT;
      sh_d        = start_word;
      idx_d       = '0;
      ser_out_d   = start_word[0];
      ser_valid_d = 1'b1;
      ser_first_d = 1'b1;
      ser_last_d  = 1'b0;
    end
  end

  // Control and output registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_full_q  <= 1'b0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_first_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      words_sent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pend_full_q  <= pend_full_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      ser_first_q  <= ser_first_d;
      ser_last_q   <= ser_last_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Datapath registers: contents are qualified by state/pend_full, no reset.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    sh_q   <= sh_d;
    pend_q <= pend_d;
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign ser_first  = ser_first_q;
  assign ser_last   = ser_last_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
module tb_serial_word_feeder;

  logic        clk;
  logic        reset;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_first;
  logic        ser_last;
  logic [15:0] words_sent;

  int total;
  int bad;

  serial_word_feeder #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream serial two's-complement stage, reset per word by ser_first.
  logic seen_q;
  logic cons_out;
  assign cons_out = ser_out ^ (ser_first ? 1'b0 : seen_q);
  always @(posedge clk) begin
    if (ser_valid) seen_q <= ser_first ? ser_out : (seen_q | ser_out);
  end

  typedef struct {
    logic        rst;
    logic        lv;
    logic [7:0]  ld;
    logic        rdy;
    logic        v;
    logic        o;
    logic        f;
    logic        l;
    logic [15:0] ws;
  } vec_t;

  vec_t vq[$];

  task automatic push(input logic r, input logic lv, input logic [7:0] ld,
                      input logic rdy, input logic v, input logic o,
                      input logic f, input logic l, input logic [15:0] ws);
    vec_t e;
    e.rst = r; e.lv = lv; e.ld = ld; e.rdy = rdy; e.v = v; e.o = o;
    e.f = f; e.l = l; e.ws = ws;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic lv, input logic [7:0] ld);
    @(negedge clk);
    reset = r; load_valid = lv; load_data = ld;
    #1;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] cons;
    total = 0; bad = 0;
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    repeat (3) @(negedge clk);

    // --- vector table ---
    push(1, 0, 8'h00, 0, 0, 0, 0, 0, 16'd0);
    push(0, 1, 8'h06, 1, 0, 0, 0, 0, 16'd0);
    w = 8'h06;
    for (int k = 0; k < 8; k++) push(0, 0, 8'h00, 1, 1, w[k], k == 0, k == 7, 16'd0);
    push(0, 1, 8'hA5, 1, 0, 0, 0, 0, 16'd1);
    w = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      if (k == 2)      push(0, 1, 8'h3C, 1, 1, w[k], 0, 0, 16'd1);
      else if (k < 2)  push(0, 0, 8'h00, 1, 1, w[k], k == 0, 0, 16'd1);
      else if (k < 7)  push(0, 1, 8'hFF, 0, 1, w[k], 0, 0, 16'd1);
      else             push(0, 0, 8'h00, 0, 1, w[k], 0, 1, 16'd1);
    end
    w = 8'h3C;
    for (int k = 0; k < 8; k++) push(0, 0, 8'h00, 1, 1, w[k], k == 0, k == 7, 16'd2);
    push(0, 1, 8'hFF, 1, 0, 0, 0, 0, 16'd3);
    w = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) push(0, 1, 8'h01, 1, 1, 1'b1, 0, 1, 16'd3);
      else        push(0, 0, 8'h00, 1, 1, 1'b1, k == 0, 0, 16'd3);
    end
    w = 8'h01;
    for (int k = 0; k < 8; k++) push(0, 0, 8'h00, 1, 1, w[k], k == 0, k == 7, 16'd4);
    push(0, 0, 8'h00, 1, 0, 0, 0, 0, 16'd5);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].lv, vq[i].ld);
      total++;
      if ({load_ready, ser_valid, ser_out, ser_first, ser_last, words_sent} !==
          {vq[i].rdy, vq[i].v, vq[i].o, vq[i].f, vq[i].l, vq[i].ws}) begin
        bad++;
        $display("FAIL row%0d: got rdy=%b v=%b o=%b f=%b l=%b ws=%0d expected rdy=%b v=%b o=%b f=%b l=%b ws=%0d",
                 i, load_ready, ser_valid, ser_out, ser_first, ser_last, words_sent,
                 vq[i].rdy, vq[i].v, vq[i].o, vq[i].f, vq[i].l, vq[i].ws);
      end
    end

    // --- reset mid-word with a word also buffered ---
    drive(0, 1, 8'hF0);
    drive(0, 0, 8'h00);                 // bit 0
    drive(0, 1, 8'h77);                 // bit 1, 8'h77 goes to buffer
    check("buffered_ready", {31'd0, load_ready}, 32'd1);
    drive(0, 0, 8'h00);                 // bit 2
    check("buffer_full_ready", {31'd0, load_ready}, 32'd0);
    drive(0, 0, 8'h00);                 // bit 3
    drive(1, 0, 8'h00);                 // bit 4 with reset
    check("bit4_out", {31'd0, ser_out}, 32'd1);
    check("ready_in_reset", {31'd0, load_ready}, 32'd0);
    drive(0, 0, 8'h00);
    check("post_reset_outs", {27'd0, ser_valid, ser_out, ser_first, ser_last, load_ready}, 32'd1);
    check("post_reset_ws", {16'd0, words_sent}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 8'h00);
      check("no_resume", {30'd0, ser_valid, ser_out}, 32'd0);
    end

    // --- chained two's-complement consumer ---
    drive(0, 1, 8'h06);
    cons = 8'h00;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 8'h00);
      cons[k] = cons_out;
    end
    check("consumer_word", {24'd0, cons}, 32'h000000FA);
    drive(0, 0, 8'h00);
    check("consumer_ws", {16'd0, words_sent}, 32'd1);

    // --- words_sent wrap ---
    @(negedge clk);
    force dut.words_sent_d = 16'hFFFF;
    @(negedge clk);
    release dut.words_sent_d;
    #1;
    check("ws_preset", {16'd0, words_sent}, 32'h0000FFFF);
    drive(0, 1, 8'h5A);
    for (int k = 0; k < 8; k++) drive(0, 0, 8'h00);
    check("ws_before_wrap", {16'd0, words_sent}, 32'h0000FFFF);
    drive(0, 0, 8'h00);
    check("ws_wrap", {16'd0, words_sent}, 32'd0);
    check("idle_after_wrap", {31'd0, ser_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
